// File: rtl/cpu_state_loader.sv
// Streams a boot image (PC, data memory, R1..R31) into CPU state while holding the CPU in reset.
// Optional trailing checksum word is verified when LOADER_CHECKSUM_EN is defined.
module cpu_state_loader #(
  parameter int unsigned DM_WORDS = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        in_valid_i,
  input  logic [31:0] in_data_i,
  output logic        in_ready_o,
  output logic        pc_we_o,
  output logic [31:0] pc_o,
  output logic        dm_we_o,
  output logic [31:0] dm_addr_o,
  output logic [31:0] dm_data_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_addr_o,
  output logic [31:0] rf_data_o,
  output logic        cpu_hold_o,
  output logic        done_o,
  output logic        err_o
);

  typedef enum logic [2:0] {
    StIdle,
    StLoadPc,
    StLoadDm,
    StLoadRf,
    StDone
`ifdef LOADER_CHECKSUM_EN
    , StCheck
`endif
  } state_e;

  state_e      r_state, w_next_state;
  logic [31:0] r_cnt;
  logic        r_pc_we, r_dm_we, r_rf_we;
  logic [31:0] r_pc, r_dm_addr, r_dm_data, r_rf_data;
  logic [4:0]  r_rf_addr;
  logic        w_acc, w_last_dm, w_last_rf;

  assign w_last_dm = (r_cnt == DM_WORDS - 1);
  assign w_last_rf = (r_cnt == 32'd30);
  assign w_acc     = in_valid_i & in_ready_o;

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] r_sum;
  logic        r_err;
  logic        w_sum_ok;
  assign w_sum_ok = (in_data_i == r_sum);
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      StIdle:   if (start_i) w_next_state = StLoadPc;
      StLoadPc: if (w_acc) w_next_state = StLoadDm;
      StLoadDm: if (w_acc && w_last_dm) w_next_state = StLoadRf;
`ifdef LOADER_CHECKSUM_EN
      StLoadRf: if (w_acc && w_last_rf) w_next_state = StCheck;
      StCheck:  if (w_acc) w_next_state = w_sum_ok ? StDone : StIdle;
`else
      StLoadRf: if (w_acc && w_last_rf) w_next_state = StDone;
`endif
      StDone:   if (start_i) w_next_state = StIdle;
      default:  w_next_state = StIdle;
    endcase
  end

  // Write port registers: one strobe per accepted word, landing the cycle after acceptance.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt     <= '0;
      r_pc_we   <= 1'b0;
      r_pc      <= '0;
      r_dm_we   <= 1'b0;
      r_dm_addr <= '0;
      r_dm_data <= '0;
      r_rf_we   <= 1'b0;
      r_rf_addr <= '0;
      r_rf_data <= '0;
    end else begin
      r_pc_we <= 1'b0;
      r_dm_we <= 1'b0;
      r_rf_we <= 1'b0;
      if (w_acc) begin
        case (r_state)
          StLoadPc: begin
            r_pc_we <= 1'b1;
            r_pc    <= in_data_i;
            r_cnt   <= '0;
          end
          StLoadDm: begin
            r_dm_we   <= 1'b1;
            r_dm_addr <= {r_cnt[29:0], 2'b00};
            r_dm_data <= in_data_i;
            r_cnt     <= w_last_dm ? '0 : r_cnt + 32'd1;
          end
          StLoadRf: begin
            r_rf_we   <= 1'b1;
            r_rf_addr <= r_cnt[4:0] + 5'd1;
            r_rf_data <= in_data_i;
            r_cnt     <= w_last_rf ? '0 : r_cnt + 32'd1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running sum of every image word ahead of the checksum; error sticks until the next start.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_sum <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == StIdle && start_i) begin
        r_sum <= '0;
        r_err <= 1'b0;
      end else if (w_acc && r_state != StCheck) begin
        r_sum <= r_sum + in_data_i;
      end else if (w_acc && r_state == StCheck && !w_sum_ok) begin
        r_err <= 1'b1;
      end
    end
  end
  assign err_o      = r_err;
  assign in_ready_o = (r_state == StLoadPc) || (r_state == StLoadDm) ||
                      (r_state == StLoadRf) || (r_state == StCheck);
`else
  assign err_o      = 1'b0;
  assign in_ready_o = (r_state == StLoadPc) || (r_state == StLoadDm) || (r_state == StLoadRf);
`endif

  assign pc_we_o    = r_pc_we;
  assign pc_o       = r_pc;
  assign dm_we_o    = r_dm_we;
  assign dm_addr_o  = r_dm_addr;
  assign dm_data_o  = r_dm_data;
  assign rf_we_o    = r_rf_we;
  assign rf_addr_o  = r_rf_addr;
  assign rf_data_o  = r_rf_data;
  assign cpu_hold_o = (r_state != StDone);
  assign done_o     = (r_state == StDone);

endmodule

// File: tb/tb_cpu_state_loader.sv
// Self-checking bench for cpu_state_loader: scenario table plus reset and checksum sequences.
module tb_cpu_state_loader;
  localparam int DM = 32;
  localparam int NW = 1 + DM + 31;
`ifdef LOADER_CHECKSUM_EN
  localparam int DefCs = 1;
`else
  localparam int DefCs = 0;
`endif

  logic        clk = 0, rst = 1, start_i = 0, in_valid = 0;
  logic [31:0] in_data = '0;
  logic        in_ready_o, pc_we_o, dm_we_o, rf_we_o, cpu_hold_o, done_o, err_o;
  logic [31:0] pc_o, dm_addr_o, dm_data_o, rf_data_o;
  logic [4:0]  rf_addr_o;

  cpu_state_loader #(.DM_WORDS(DM)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready_o), .pc_we_o(pc_we_o), .pc_o(pc_o), .dm_we_o(dm_we_o),
    .dm_addr_o(dm_addr_o), .dm_data_o(dm_data_o), .rf_we_o(rf_we_o), .rf_addr_o(rf_addr_o),
    .rf_data_o(rf_data_o), .cpu_hold_o(cpu_hold_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    bit          gap;
    int          start_at;
    logic [31:0] exp_pc;
    logic [31:0] exp_m5;
    logic [31:0] exp_r31;
    int          exp_strobes;
  } vec_t;

  exp_t        q[$];
  int          n_cmp = 0, n_bad = 0, n_strobe = 0;
  logic [31:0] tb_mem [DM];
  logic [31:0] tb_rf [32];
  logic [31:0] tb_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int i);
    if (i == 0) return 32'h40;
    if (i <= DM) return 32'(i - 1);
    return 32'(100 + (i - DM));
  endfunction

  // Strobe monitor: every write must match the next expected entry.
  always @(negedge clk) begin
    if (!rst) begin
      int   n;
      exp_t a, e;
      n = int'(pc_we_o) + int'(dm_we_o) + int'(rf_we_o);
      if (n > 1) check("one_hot_strobe", 32'(n), 32'd1);
      if (n > 0) begin
        n_strobe++;
        a.kind = pc_we_o ? 0 : (dm_we_o ? 1 : 2);
        a.addr = pc_we_o ? 32'd0 : (dm_we_o ? dm_addr_o : {27'd0, rf_addr_o});
        a.data = pc_we_o ? pc_o : (dm_we_o ? dm_data_o : rf_data_o);
        if (pc_we_o) tb_pc = pc_o;
        else if (dm_we_o && (dm_addr_o >> 2) < DM) tb_mem[dm_addr_o >> 2] = dm_data_o;
        else if (rf_we_o) tb_rf[rf_addr_o] = rf_data_o;
        if (q.size() == 0) begin
          check("spurious_strobe", 32'(a.kind), 32'hffffffff);
        end else begin
          e = q.pop_front();
          check("strobe_kind", 32'(a.kind), 32'(e.kind));
          check("strobe_addr", a.addr, e.addr);
          check("strobe_data", a.data, e.data);
        end
      end
    end
  end

  task automatic clear_model();
    for (int i = 0; i < DM; i++) tb_mem[i] = 32'hdeadbeef;
    for (int i = 0; i < 32; i++) tb_rf[i] = 32'hdeadbeef;
    tb_pc = 32'hdeadbeef;
  endtask

  task automatic pulse_start();
    start_i = 1;
    @(posedge clk); #1;
    start_i = 0;
  endtask

  task automatic send_word(input logic [31:0] d, input int idx, input bit push);
    bit   acc, r;
    exp_t e;
    in_valid = 1;
    in_data  = d;
    acc = 0;
    for (int t = 0; t < 20 && !acc; t++) begin
      @(negedge clk);
      r = in_ready_o;
      @(posedge clk);
      if (r) acc = 1;
    end
    if (!acc) check("ready_timeout", 32'd0, 32'd1);
    if (acc && push) begin
      e.data = d;
      if (idx == 0) begin e.kind = 0; e.addr = 0; end
      else if (idx <= DM) begin e.kind = 1; e.addr = 32'(4 * (idx - 1)); end
      else begin e.kind = 2; e.addr = 32'(idx - DM); end
      q.push_back(e);
    end
    #1;
    in_valid = 0;
  endtask

  task automatic stream_image(input vec_t v, output logic [31:0] sum);
    sum = 0;
    clear_model();
    n_strobe = 0;
    pulse_start();
    for (int i = 0; i < NW; i++) begin
      if (i == v.start_at) start_i = 1;
      send_word(word_of(i), i, 1);
      start_i = 0;
      sum += word_of(i);
      if (v.gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic settle();
    in_valid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
  endtask

  vec_t        vecs[3];
  logic [31:0] sum;
  int          bad_words;

  initial begin
    vecs[0] = '{gap: 0, start_at: -1, exp_pc: 32'h40, exp_m5: 32'd5, exp_r31: 32'd131,
                exp_strobes: NW};
    vecs[1] = '{gap: 1, start_at: -1, exp_pc: 32'h40, exp_m5: 32'd5, exp_r31: 32'd131,
                exp_strobes: NW};
    vecs[2] = '{gap: 0, start_at: 10, exp_pc: 32'h40, exp_m5: 32'd5, exp_r31: 32'd131,
                exp_strobes: NW};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(in_ready_o), 0);
    check("rst_hold", 32'(cpu_hold_o), 1);
    check("rst_done", 32'(done_o), 0);
    check("rst_err", 32'(err_o), 0);
    check("rst_strobes", {29'd0, pc_we_o, dm_we_o, rf_we_o}, 0);
    check("rst_dm_addr", dm_addr_o, 0);
    check("rst_pc", pc_o, 0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    check("idle_ready", 32'(in_ready_o), 0);
    @(posedge clk); #1;

    for (int s = 0; s < 3; s++) begin
      stream_image(vecs[s], sum);
      if (DefCs != 0) send_word(sum, 0, 0);
      settle();
      check($sformatf("s%0d_queue_empty", s), 32'(q.size()), 0);
      check($sformatf("s%0d_strobes", s), 32'(n_strobe), 32'(vecs[s].exp_strobes));
      check($sformatf("s%0d_pc", s), tb_pc, vecs[s].exp_pc);
      check($sformatf("s%0d_mem5", s), tb_mem[5], vecs[s].exp_m5);
      check($sformatf("s%0d_r31", s), tb_rf[31], vecs[s].exp_r31);
      bad_words = 0;
      for (int i = 0; i < DM; i++) if (tb_mem[i] !== word_of(i + 1)) bad_words++;
      for (int k = 1; k < 32; k++) if (tb_rf[k] !== word_of(DM + k)) bad_words++;
      check($sformatf("s%0d_image_words", s), 32'(bad_words), 0);
      check($sformatf("s%0d_done", s), 32'(done_o), 1);
      check($sformatf("s%0d_hold", s), 32'(cpu_hold_o), 0);
      check($sformatf("s%0d_err", s), 32'(err_o), 0);
      check($sformatf("s%0d_ready_done", s), 32'(in_ready_o), 0);
      pulse_start();
      @(negedge clk);
      check($sformatf("s%0d_back_idle_done", s), 32'(done_o), 0);
      check($sformatf("s%0d_back_idle_hold", s), 32'(cpu_hold_o), 1);
      @(posedge clk); #1;
    end

    // Reset after ten accepted words: the 11th word offered must never land.
    clear_model();
    n_strobe = 0;
    pulse_start();
    for (int i = 0; i < 10; i++) send_word(word_of(i), i, 1);
    @(negedge clk); #1;
    check("mid_strobes_before", 32'(n_strobe), 10);
    in_valid = 1;
    in_data  = word_of(10);
    rst      = 1;
    #1;
    check("mid_rst_dm_we", 32'(dm_we_o), 0);
    check("mid_rst_dm_addr", dm_addr_o, 0);
    check("mid_rst_dm_data", dm_data_o, 0);
    check("mid_rst_pc", pc_o, 0);
    check("mid_rst_ready", 32'(in_ready_o), 0);
    check("mid_rst_hold", 32'(cpu_hold_o), 1);
    repeat (3) @(posedge clk);
    #1;
    rst      = 0;
    in_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("mid_strobes_after", 32'(n_strobe), 10);
    check("mid_mem8_kept", tb_mem[8], 32'd8);
    check("mid_mem9_unwritten", tb_mem[9], 32'hdeadbeef);
    check("mid_queue_empty", 32'(q.size()), 0);
    @(posedge clk); #1;

`ifdef LOADER_CHECKSUM_EN
    // Checksum off by one: back to IDLE with a sticky error and the CPU still held.
    stream_image(vecs[0], sum);
    send_word(sum + 32'd1, 0, 0);
    settle();
    check("cs_bad_err", 32'(err_o), 1);
    check("cs_bad_done", 32'(done_o), 0);
    check("cs_bad_hold", 32'(cpu_hold_o), 1);
    check("cs_bad_ready", 32'(in_ready_o), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("cs_err_sticky", 32'(err_o), 1);
    @(posedge clk); #1;
    pulse_start();
    @(negedge clk);
    check("cs_err_cleared", 32'(err_o), 0);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
